reg_wb_arbiter: RTL and testbench

//  Write-back arbiter and scoreboard for the single write port of the 32x32 register file.

---
 rtl/reg_wb_arbiter.sv | 100 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin write-back arbiter for ALU/load slots with a RAW pending-register scoreboard.
// Defining WB_FWD_EN enables forwarding of the committing value to rs1/rs2.
module reg_wb_arbiter #(
  parameter int NREGS = 32,
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_rd,
  input  logic [DW-1:0] ld_data,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ok,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rs1_fwd_v,
  output logic          rs2_fwd_v,
  output logic [DW-1:0] rs1_fwd_d,
  output logic [DW-1:0] rs2_fwd_d,
  output logic          reg_write,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic [DW-1:0] mem_load_data,
  output logic          load_enable,
  output logic [CW-1:0] conflict_cnt
);
  logic          alu_v, ld_v, last_ld, grant_alu, grant_ld;
  logic [AW-1:0] alu_rd_q, ld_rd_q;
  logic [DW-1:0] alu_d_q, ld_d_q;
  logic [NREGS-1:0] pending, pending_n;
  // on a tie the slot that did not win last time goes first
  assign grant_ld      = ld_v && (!alu_v || !last_ld);
  assign grant_alu     = alu_v && (!ld_v || last_ld);
  assign reg_write     = grant_alu || grant_ld;
  assign load_enable   = grant_ld;
  assign write_reg     = grant_ld ? ld_rd_q : alu_rd_q;
  assign write_data    = alu_d_q;
  assign mem_load_data = ld_d_q;
  assign alu_ready     = !alu_v;
  assign ld_ready      = !ld_v;
  assign issue_ok      = !pending[issue_rd] || issue_rd == '0;
`ifdef WB_FWD_EN
  logic [DW-1:0] commit_d;
  assign commit_d  = grant_ld ? ld_d_q : alu_d_q;
  assign rs1_fwd_v = reg_write && rs1 != '0 && write_reg == rs1;
  assign rs2_fwd_v = reg_write && rs2 != '0 && write_reg == rs2;
  assign rs1_fwd_d = rs1_fwd_v ? commit_d : '0;
  assign rs2_fwd_d = rs2_fwd_v ? commit_d : '0;
  assign rs1_busy  = pending[rs1] && rs1 != '0 && !rs1_fwd_v;
  assign rs2_busy  = pending[rs2] && rs2 != '0 && !rs2_fwd_v;
`else
  assign rs1_fwd_v = 1'b0;
  assign rs2_fwd_v = 1'b0;
  assign rs1_fwd_d = '0;
  assign rs2_fwd_d = '0;
  assign rs1_busy  = pending[rs1] && rs1 != '0;
  assign rs2_busy  = pending[rs2] && rs2 != '0;
`endif
  // a new issue to the committing register must stay pending, so set follows clear
  always_comb begin
    pending_n = pending;
    if (reg_write) pending_n[write_reg] = 1'b0;
    if (issue_valid && issue_rd != '0) pending_n[issue_rd] = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_v        <= 1'b0;
      ld_v         <= 1'b0;
      last_ld      <= 1'b0;
      pending      <= '0;
      conflict_cnt <= '0;
    end else begin
      pending <= pending_n;
      if (alu_v && ld_v && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
      if (reg_write) last_ld <= grant_ld;
      if (grant_alu) alu_v <= 1'b0;
      else if (alu_valid && !alu_v) alu_v <= alu_rd != '0;
      if (grant_ld) ld_v <= 1'b0;
      else if (ld_valid && !ld_v) ld_v <= ld_rd != '0;
      if (alu_valid && !alu_v) begin
        alu_rd_q <= alu_rd;
        alu_d_q  <= alu_data;
      end
      if (ld_valid && !ld_v) begin
        ld_rd_q <= ld_rd;
        ld_d_q  <= ld_data;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed bench for reg_wb_arbiter with a per-cycle reference model.
module tb_reg_wb_arbiter;
  logic        clock = 1'b0, reset = 1'b1;
  logic        alu_valid, alu_ready, ld_valid, ld_ready, issue_valid, issue_ok;
  logic [4:0]  alu_rd, ld_rd, issue_rd, rs1, rs2, write_reg;
  logic [31:0] alu_data, ld_data, rs1_fwd_d, rs2_fwd_d, write_data, mem_load_data;
  logic        rs1_busy, rs2_busy, rs1_fwd_v, rs2_fwd_v, reg_write, load_enable;
  logic [15:0] conflict_cnt;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  int checks = 0, errors = 0;
  // model: index 0 = ALU slot, 1 = load slot; mlast is the index of the last winner
  bit          mv[2];
  logic [4:0]  mrd[2];
  logic [31:0] md[2];
  int          mlast;
  bit          mpend[32];
  int          mcc;

  always #5 clock = ~clock;

  reg_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(issue_ok),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd_v(rs1_fwd_v), .rs2_fwd_v(rs2_fwd_v), .rs1_fwd_d(rs1_fwd_d), .rs2_fwd_d(rs2_fwd_d),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_load_data(mem_load_data), .load_enable(load_enable), .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (mv[0] && mv[1]) return 1 - mlast;
    return mv[1] ? 1 : 0;
  endfunction

  task automatic compare();
    bit cm, f1, f2;
    int w;
    cm = mv[0] || mv[1];
    w  = winner();
    f1 = FWD && cm && rs1 != 0 && mrd[w] == rs1;
    f2 = FWD && cm && rs2 != 0 && mrd[w] == rs2;
    chk("reg_write", reg_write, cm);
    chk("alu_ready", alu_ready, !mv[0]);
    chk("ld_ready", ld_ready, !mv[1]);
    chk("issue_ok", issue_ok, issue_rd == 0 || !mpend[issue_rd]);
    chk("rs1_busy", rs1_busy, mpend[rs1] && rs1 != 0 && !f1);
    chk("rs2_busy", rs2_busy, mpend[rs2] && rs2 != 0 && !f2);
    chk("rs1_fwd_v", rs1_fwd_v, f1);
    chk("rs2_fwd_v", rs2_fwd_v, f2);
    chk("conflict_cnt", conflict_cnt, mcc);
    if (cm) begin
      chk("write_reg", write_reg, mrd[w]);
      chk("load_enable", load_enable, w == 1);
      if (w == 0) chk("write_data", write_data, md[0]);
      else chk("mem_load_data", mem_load_data, md[1]);
    end
    if (f1 || !FWD) chk("rs1_fwd_d", rs1_fwd_d, f1 ? md[w] : 0);
    if (f2 || !FWD) chk("rs2_fwd_d", rs2_fwd_d, f2 ? md[w] : 0);
  endtask

  task automatic update();
    bit r0, r1;
    int w;
    if (reset) begin
      mv[0] = 0; mv[1] = 0; mlast = 0; mcc = 0;
      foreach (mpend[i]) mpend[i] = 0;
    end else begin
      r0 = !mv[0];
      r1 = !mv[1];
      w  = winner();
      if (mv[0] && mv[1] && mcc < 65535) mcc++;
      if (mv[0] || mv[1]) begin
        mpend[mrd[w]] = 0;
        mv[w] = 0;
        mlast = w;
      end
      if (issue_valid && issue_rd != 0) mpend[issue_rd] = 1;
      if (alu_valid && r0 && alu_rd != 0) begin mv[0] = 1; mrd[0] = alu_rd; md[0] = alu_data; end
      if (ld_valid && r1 && ld_rd != 0) begin mv[1] = 1; mrd[1] = ld_rd; md[1] = ld_data; end
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    compare();
    @(posedge clock);
    update();
    #1;
  endtask

  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    @(posedge clock); update(); #1;
    cyc();
    reset = 0;
    chk("rst_reg_write", reg_write, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_conflict", conflict_cnt, 0);
    // uncontended ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    cyc();
    alu_valid = 0;
    chk("t1_reg_write", reg_write, 1);
    chk("t1_write_reg", write_reg, 5);
    chk("t1_load_enable", load_enable, 0);
    chk("t1_write_data", write_data, 32'h1234);
    chk("t1_alu_ready", alu_ready, 0);
    cyc();
    chk("t1_idle", reg_write, 0);
    // first tie after reset goes to load
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33; ld_valid = 1; ld_rd = 4; ld_data = 32'h44;
    cyc();
    alu_valid = 0; ld_valid = 0;
    chk("t2_load_first", load_enable, 1);
    chk("t2_write_reg_ld", write_reg, 4);
    chk("t2_ld_data", mem_load_data, 32'h44);
    cyc();
    chk("t2_alu_next", load_enable, 0);
    chk("t2_write_reg_alu", write_reg, 3);
    chk("t2_conflict", conflict_cnt, 1);
    cyc();
    // rd 0 is swallowed
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    chk("t3_ready", alu_ready, 1);
    cyc();
    alu_valid = 0;
    chk("t3_no_write", reg_write, 0);
    chk("t3_ready_after", alu_ready, 1);
    // scoreboard and forwarding
    issue_valid = 1; issue_rd = 7;
    cyc();
    rs1 = 7;
    #1;
    chk("t4_busy", rs1_busy, 1);
    chk("t4_issue_ok", issue_ok, 0);
    cyc();
    issue_valid = 0;
    ld_valid = 1; ld_rd = 7; ld_data = 9;
    cyc();
    ld_valid = 0; rs2 = 7;
    #1;
    chk("t5_fwd_v", rs2_fwd_v, FWD);
    chk("t5_fwd_d", rs2_fwd_d, FWD ? 9 : 0);
    chk("t5_busy", rs2_busy, !FWD);
    cyc();
    chk("t4_cleared", rs1_busy, 0);
    chk("t4_issue_ok_after", issue_ok, 1);
    // same-cycle set and clear keeps the bit
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    cyc();
    ld_valid = 0; issue_valid = 1; issue_rd = 9;
    cyc();
    issue_valid = 0; rs1 = 9;
    #1;
    chk("set_wins", rs1_busy, 1);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h5;
    cyc();
    alu_valid = 0;
    cyc();
    chk("set_cleared", rs1_busy, 0);
    // after a load-only commit, the next tie goes to ALU
    ld_valid = 1; ld_rd = 10; ld_data = 32'hA;
    cyc();
    ld_valid = 0;
    cyc();
    alu_valid = 1; alu_rd = 11; alu_data = 32'hB; ld_valid = 1; ld_rd = 12; ld_data = 32'hC;
    cyc();
    alu_valid = 0; ld_valid = 0;
    chk("rr_alu_wins", write_reg, 11);
    cyc();
    chk("rr_ld_next", write_reg, 12);
    cyc();
    // mixed traffic, model-checked each cycle
    for (int i = 0; i < 48; i++) begin
      alu_valid = (i % 3) != 0; alu_rd = 5'(i % 8); alu_data = 32'(i * 17);
      ld_valid = (i % 2) == 0; ld_rd = 5'((i * 3) % 32); ld_data = 32'(i * 31 + 1);
      issue_valid = (i % 4) == 1; issue_rd = 5'((i * 7) % 32);
      rs1 = 5'((i * 5) % 32); rs2 = 5'((i * 3 + 3) % 32);
      cyc();
    end
    alu_valid = 0; ld_valid = 0; issue_valid = 0;
    repeat (3) cyc();
    // reset with both slots held
    alu_valid = 1; alu_rd = 13; alu_data = 1; ld_valid = 1; ld_rd = 14; ld_data = 2;
    issue_valid = 1; issue_rd = 15;
    cyc();
    alu_valid = 0; ld_valid = 0; issue_valid = 0;
    reset = 1;
    cyc();
    reset = 0; rs1 = 15; rs2 = 13;
    #1;
    chk("t6_reg_write", reg_write, 0);
    chk("t6_alu_ready", alu_ready, 1);
    chk("t6_ld_ready", ld_ready, 1);
    chk("t6_busy1", rs1_busy, 0);
    chk("t6_busy2", rs2_busy, 0);
    chk("t6_conflict", conflict_cnt, 0);
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
